// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
//
// The CPU-side bus glue pushes bytes with wr_en/wr_data. A serialiser
// pops them and shifts them out LSB first, with one start bit and one
// stop bit. While the FIFO has data, frames go out back-to-back with no
// idle gap.
//
// Parameters
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  serial bit rate; one bit lasts CLK_FREQ/BAUD_RATE clocks
//   FIFO_DEPTH FIFO entries (power of two, >= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   wr_data    byte to enqueue
//   wr_en      enqueue strobe; dropped silently when the FIFO is full
//   tx_full    FIFO holds FIFO_DEPTH entries (registered)
//   tx_busy    serialiser not idle (registered)
//   fifo_count entries currently queued (registered)
//   tx         serial line, idles high (registered)
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          tx_full,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx
);

  localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVIDER - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_nxt;
  logic                push;
  logic                pop;
  logic                fifo_nonempty;

  logic [BAUD_W-1:0]   baud_cnt;
  logic                baud_end;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic                shift_load;
  logic                shift_adv;
  logic                tx_nxt;

  // Acceptance is judged on the count before this edge's pop, so a write
  // that lands on the same edge as a pop from a full FIFO is still dropped.
  assign push          = wr_en && (count < CNT_FULL);
  assign fifo_nonempty = (count != '0);
  assign baud_end      = (baud_cnt == BAUD_LAST);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // ---- FIFO storage and pointers ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_full <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      tx_full <= (count_nxt == CNT_FULL);
    end
  end

  assign fifo_count = count;

  // ---- serialiser: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- serialiser: next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (fifo_nonempty) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end && (bit_idx == 3'd7)) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Chaining straight into START keeps consecutive frames gap-free.
        if (baud_end) begin
          state_nxt = fifo_nonempty ? S_START : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- serialiser: output / datapath control ----
  always_comb begin
    tx_nxt     = tx;
    pop        = 1'b0;
    shift_load = 1'b0;
    shift_adv  = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_load = 1'b1;
          tx_nxt     = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          tx_nxt = shift[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
            tx_nxt = 1'b1;
          end else begin
            // shift[1] is the bit that becomes shift[0] after this edge.
            shift_adv = 1'b1;
            tx_nxt    = shift[1];
          end
        end
      end
      S_STOP: begin
        tx_nxt = 1'b1;
        if (baud_end && fifo_nonempty) begin
          pop        = 1'b1;
          shift_load = 1'b1;
          tx_nxt     = 1'b0;
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  // ---- baud timing and bit index ----
  // The counter sits at zero in IDLE, so the first bit after leaving IDLE
  // gets a full DIVIDER clocks; every bit boundary restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if ((state == S_IDLE) || baud_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      if (state != S_DATA) begin
        bit_idx <= '0;
      end else if (baud_end) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // ---- shift register (data path, not reset) ----
  always_ff @(posedge clk) begin
    if (shift_load) begin
      shift <= fifo_mem[rd_ptr];
    end else if (shift_adv) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // ---- line and status outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx      <= tx_nxt;
      tx_busy <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter with a small byte FIFO for the serial console path. Fixed frame format 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit). The CPU-side bus glue pushes bytes into the FIFO. The block serialises them back-to-back onto the TX line, which idles high. It pairs with uart_rx at the same CLK_FREQ/BAUD_RATE.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate in bits/s; DIVIDER = CLK_FREQ / BAUD_RATE (integer truncation, 217 at defaults)
FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_data  input  8  byte to enqueue
wr_en  input  1  enqueue strobe, sampled every rising edge
tx_full  output  1  FIFO holds FIFO_DEPTH entries (registered)
tx_busy  output  1  serialiser not in IDLE (registered)
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued (registered)
tx  output  1  serial line, idle high (registered, glitch-free)

Behaviour:
- Reset: tx=1, tx_busy=0, tx_full=0, fifo_count=0, FIFO pointers=0, state=IDLE, baud counter=0, bit index=0.
- Reset applies mid-frame. The line returns high on the next edge. All queued data is discarded.
- Write acceptance: a write is accepted iff wr_en=1 and fifo_count<FIFO_DEPTH, evaluated before any same-cycle pop. A write while full is silently dropped; FIFO contents are unchanged.
- Simultaneous accepted write and pop: fifo_count is unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- tx_full and fifo_count reflect the state after the current edge's push/pop.
- Serialiser states:
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register, drive tx<=0, clear the baud counter, go to START.
  - START: hold tx=0 for DIVIDER clocks, then drive tx<=shift[0], bit index=0, go to DATA.
  - DATA: each bit is held for exactly DIVIDER clocks. At the end of bit n (n<7), shift and drive the next bit. At the end of bit 7, drive tx<=1 and go to STOP.
  - STOP: hold tx=1 for DIVIDER clocks. At the end, if fifo_count>0, pop and go directly to START with tx<=0, so there is no extra idle time between frames. Otherwise go to IDLE.
- Timing:
  - Every bit lasts exactly DIVIDER clocks; a frame is exactly 10*DIVIDER clocks.
  - The baud counter runs 0..DIVIDER-1 and restarts at 0 at each bit boundary.
- Latency: a write accepted at edge N with the FIFO empty and state IDLE makes tx fall at edge N+1. That is one cycle after the FIFO update.
- tx_busy is 1 from the edge tx falls for a start bit until the edge that returns to IDLE. It stays 1 across back-to-back frames.
- A pop occurs only in IDLE (fifo_count>0) or at the end of STOP. There is never more than one pop per cycle.
- Unused state encodings return to IDLE with tx=1.
- No parity, no break generation, no flow control.

Test Plan:
- Reset: assert rst 3 cycles mid-stream, release -> tx=1, tx_busy=0, tx_full=0, fifo_count=0 on the first edge after release; no further line activity.
- Single byte: CLK_FREQ=1000000, BAUD_RATE=100000 (DIVIDER=10); write 0x55 while idle -> tx falls exactly 1 cycle after the write edge. Line then carries 0,1,0,1,0,1,0,1,0,1, each held 10 cycles. tx_busy drops after 100 cycles; fifo_count reads 1 for one cycle, then 0.
- Back-to-back: same params, write 0x01,0x80,0xFF,0x00 on consecutive cycles -> tx_full never asserts (pops free a slot). Four frames of 100 cycles each appear with no gap between stop bit and next start bit; tx_busy stays high for 400 cycles.
- Overflow: pause serialisation by writing 5 bytes while the first frame is in START, then write 0xAA while full -> 0xAA is dropped, fifo_count stays 4, tx_full=1. Serial output is exactly the first 5 bytes, in order.
- Write on pop cycle: with FIFO full (count=4), issue a write on the STOP-end pop cycle -> write dropped and count becomes 3. With count=3, the same timing keeps count=3 and the byte is accepted.
- Loopback: default params, tx wired to uart_rx; send 0x00, 0xA5, 0xFF, 0x3C -> uart_rx outputs the same bytes in order with rx_ready asserting after each stop bit; no framing rejects.
